// File: rtl/decode_buffer.sv
// decode_buffer: in-order FIFO of decoded instruction fields + PC between decoder and dispatch; flush drops all entries.
// Latency: 1 cycle write-to-read; 0 cycles into an empty buffer when DECODE_BUFFER_BYPASS_EN is defined.
// Backpressure: in_ready = (count != DEPTH) from registered state only, so a full buffer refuses a push even while popping.
module decode_buffer #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [11:0]              in_opcode,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [15:0]              in_immediate,
  input  logic [25:0]              in_address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [11:0]              out_opcode,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic [15:0]              out_immediate,
  output logic [25:0]              out_address,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [11:0]     opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [15:0]     immediate;
    logic [25:0]     address;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        in_ent;
  entry_t        out_ent;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          byp;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;

  assign in_ent = {in_pc, in_opcode, in_rs, in_rt, in_rd, in_shamt, in_immediate, in_address};

`ifdef DECODE_BUFFER_BYPASS_EN
  assign byp = rst && !flush && (count == '0) && in_valid;
`else
  assign byp = 1'b0;
`endif

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0) || byp;
  assign push      = in_valid && in_ready && rst && !flush;
  assign pop       = out_valid && out_ready && rst && !flush;
  // A bypassed instruction that is consumed immediately never touches storage.
  assign wr_en     = push && !(byp && out_ready);
  assign rd_en     = pop && !byp;

  always_comb begin
    out_ent = '0;
    if (byp)
      out_ent = in_ent;
    else if (out_valid)
      out_ent = mem[head];
  end

  assign {out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_immediate, out_address} = out_ent;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en)
        tail <= tail + 1'b1;
      if (rd_en)
        head <= head + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is deliberately left uncleared; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[tail] <= in_ent;
  end
endmodule

// File: tb/tb_decode_buffer.sv
// Scoreboard bench for decode_buffer: a queue-based model predicts occupancy, head and transfer order.
module tb_decode_buffer;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
`ifdef DECODE_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] addr;
  } ent_t;

  typedef struct {
    bit   chk;
    int   cnt;
    bit   ir;
    bit   ov;
    ent_t head;
  } stat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  ent_t        din;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [11:0] out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [15:0] out_immediate;
  logic [25:0] out_address;
  logic [2:0]  count;

  int    total = 0;
  int    bad   = 0;
  bit    known = 1'b0;
  ent_t  model_q[$];
  ent_t  data_q[$];
  stat_t stat_q[$];

  decode_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(din.pc), .in_opcode(din.opcode), .in_rs(din.rs), .in_rt(din.rt),
    .in_rd(din.rd), .in_shamt(din.shamt), .in_immediate(din.imm), .in_address(din.addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_shamt(out_shamt), .out_immediate(out_immediate),
    .out_address(out_address), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.pc     = $urandom;
    e.opcode = 12'($urandom);
    e.rs     = 5'($urandom);
    e.rt     = 5'($urandom);
    e.rd     = 5'($urandom);
    e.shamt  = 5'($urandom);
    e.imm    = 16'($urandom);
    e.addr   = 26'($urandom);
    return e;
  endfunction

  // One decoder cycle: drive after the falling edge, predict the visible state, then advance the model.
  task automatic step(input bit r, input bit f, input bit iv, input bit ordy, input ent_t e);
    stat_t s;
    bit    vld;
    bit    rdy;
    @(negedge clk);
    #1;
    rst = r; flush = f; in_valid = iv; out_ready = ordy; din = e;
    rdy = (model_q.size() < DEPTH);
    vld = (model_q.size() > 0) || (BYP && iv && r && !f);
    s.chk  = known;
    s.cnt  = model_q.size();
    s.ir   = rdy;
    s.ov   = vld;
    s.head = !vld ? ent_t'('0) : (model_q.size() > 0 ? model_q[0] : e);
    stat_q.push_back(s);
    if (!r || f) begin
      model_q.delete();
      data_q.delete();
      if (!r) known = 1'b1;
    end else begin
      if (iv && rdy) begin
        model_q.push_back(e);
        data_q.push_back(e);
      end
      if (vld && ordy) void'(model_q.pop_front());
    end
  endtask

  initial begin
    stat_t s;
    ent_t  act;
    ent_t  exp_e;
    forever begin
      @(negedge clk);
      #3;
      act = {out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_immediate, out_address};
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        if (s.chk) begin
          check("count", 128'(count), 128'(s.cnt));
          check("in_ready", 128'(in_ready), 128'(s.ir));
          check("out_valid", 128'(out_valid), 128'(s.ov));
          check("head_fields", 128'(act), 128'(s.head));
        end
      end
      if (out_valid === 1'b1 && out_ready && rst && !flush) begin
        if (data_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got pc %0h want no transfer at %0t", out_pc, $time);
        end else begin
          exp_e = data_q.pop_front();
          check("pop_data", 128'(act), 128'(exp_e));
        end
      end
    end
  end

  initial begin
    ent_t e;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;

    e = rnd_ent();
    step(0, 0, 1, 0, e);
    step(0, 0, 1, 1, e);

    // Fill to DEPTH, attempt a fifth push, then drain.
    for (int i = 0; i < 5; i++) begin
      e = rnd_ent(); e.pc = 32'(i);
      step(1, 0, 1, 0, e);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, rnd_ent());

    for (int i = 1; i <= 10; i++) begin
      e = rnd_ent(); e.opcode = 12'h020; e.rs = 5'(i);
      step(1, 0, 1, 1, e);
    end
    for (int i = 0; i < 2; i++) step(1, 0, 0, 1, rnd_ent());

    // Simultaneous push and pop at count 2.
    step(1, 0, 1, 0, rnd_ent());
    step(1, 0, 1, 0, rnd_ent());
    step(1, 0, 1, 1, rnd_ent());
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, rnd_ent());

    // Flush at count 3 with a competing push and pop.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, rnd_ent());
    step(1, 1, 1, 1, rnd_ent());
    step(1, 0, 0, 1, rnd_ent());
    step(1, 0, 0, 1, rnd_ent());

    e = rnd_ent(); e.pc = 32'h40;
    step(1, 0, 1, 1, e);
    step(1, 0, 0, 1, rnd_ent());
    step(1, 0, 0, 1, rnd_ent());

    // Reset mid-stream, together with flush.
    step(1, 0, 1, 0, rnd_ent());
    step(1, 0, 1, 0, rnd_ent());
    step(0, 1, 1, 1, rnd_ent());
    step(1, 0, 0, 0, rnd_ent());

    for (int i = 0; i < 400; i++)
      step(($urandom % 60) != 0, ($urandom % 25) == 0, ($urandom % 4) != 0,
           ($urandom % 3) != 0, rnd_ent());

    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, rnd_ent());
    @(negedge clk);
    #5;
    check("drain_empty", 128'(data_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_buffer.md
# decode_buffer

Decoded-instruction FIFO between the instruction queue/decoder and the dispatch stage that allocates reservation stations. It captures the decoded fields (opcode, rs, rt, rd, shamt, immediate, address) with the fetch PC whenever the decoder presents a valid instruction. It releases entries in order under a valid/ready handshake. A flush input discards all buffered work on branch redirect.

## Interface
- DEPTH, 4: number of entries; power of two, minimum 2.
- PC_W, 32: width of the stored PC.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- flush  in  1  discard all entries (branch/jump redirect).
- in_valid  in  1  decoder presents an instruction (driven from VALID_Inst).
- in_ready  out  1  buffer can accept this cycle.
- in_pc  in  PC_W  PC of the incoming instruction.
- in_opcode  in  12  {op[5:0], funct[5:0]}; funct is zero for non-R-type.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_immediate  in  16  I-type immediate.
- in_address  in  26  J-type target.
- out_valid  out  1  head entry available.
- out_ready  in  1  dispatch consumes the head this cycle.
- out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_immediate, out_address  out  same widths  head entry fields.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is DEPTH entries of {pc, opcode, rs, rt, rd, shamt, immediate, address}, managed with a head and a tail pointer.
- Both pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- push = in_valid && in_ready; the entry is written at the tail and the tail advances.
- pop = out_valid && out_ready; the head advances.
- in_ready = (count != DEPTH). It depends only on registered state and has no combinational path from out_ready. A full buffer therefore refuses a push even when a pop occurs in the same cycle.
- out_valid = (count != 0). When out_valid=0, every out_* field is driven to 0.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- Priority, highest first: rst low, then flush, then push/pop.
  - Reset or flush sets head=tail=0 and count=0.
  - A push or pop presented in a flush cycle is dropped.
- Storage contents are not cleared by reset or flush. Only the pointers and count are reset.
- in_valid while in_ready=0: no write. The decoder must hold its fields until they are accepted.
- out_ready while out_valid=0: ignored, and count never underflows.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, all out_* fields 0.
- Write-to-read latency is 1 cycle: an entry pushed at rising edge N is visible on the outputs after edge N.
- The out_* fields are a combinational read of the head entry, so they change only after a clock edge.
- The decoder updates its outputs on the falling edge of clk. Its fields are therefore stable for half a cycle before the rising edge that samples them; no extra register stage is required.
- Flush takes effect at the edge where it is sampled high. After that edge out_valid=0 and in_ready=1.
- Reset asserted mid-stream behaves identically to flush, and additionally forces rst priority over flush.

## Configuration
- DECODE_BUFFER_BYPASS_EN defined:
  - When count==0 and in_valid=1, the input fields are forwarded combinationally to the outputs and out_valid=1 in the same cycle.
  - If out_ready is also 1, the instruction is consumed without being written and count stays 0.
  - If out_ready=0, the instruction is written normally.
  - Bypass is suppressed while flush=1.
- Macro undefined: no combinational path from the in_* ports to the out_* ports; minimum latency is 1 cycle.

## Test plan
- Reset: drive rst=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, all outputs 0.
- Fill/drain, DEPTH=4, out_ready=0: push PCs 0,1,2,3 -> count=4, in_ready=0. A fifth push with PC=4 is refused. Then hold out_ready=1 -> out_pc sequence 0,1,2,3, then out_valid=0.
- Wrap-around: run 10 push/pop pairs with opcode 12'h020 and rs incrementing 1..10 -> outputs appear in order with fields intact and count stays at most 1.
- Simultaneous push/pop at count=2 -> count remains 2 and the head advances by one.
- Flush with count=3 while in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0; the flushed-cycle input is not stored.
- Bypass (macro defined): empty buffer, in_valid=1, out_ready=1, in_pc=32'h40 -> out_pc=32'h40 and out_valid=1 in the same cycle, and count stays 0. With the macro undefined the same stimulus gives out_valid=1 one cycle later.
